// File: rtl/dmem_pkg.sv
// Shared defaults and state encoding for the data-memory copy engine.
package dmem_pkg;

    localparam int ADDR_W         = 10;
    localparam int DATA_W         = 16;
    localparam int MEM_RD_LATENCY = 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } copy_state_t;

endpackage

// File: rtl/dmem_copy_engine.sv
// Pipelined word copy SRC->DST over a 1-cycle-latency memory, 1 word/clk, done len+2 cycles after start.
// No backpressure: the memory always accepts; start is ignored unless IDLE.
module dmem_copy_engine #(
    parameter int ADDR_W = dmem_pkg::ADDR_W,
    parameter int DATA_W = dmem_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_adr,
    input  logic [ADDR_W-1:0] dst_adr,
    input  logic [ADDR_W:0]   len,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] checksum,
    output logic [ADDR_W-1:0] mem_rd_adr,
    input  logic [DATA_W-1:0] mem_rd_dat,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_wr_adr,
    output logic [DATA_W-1:0] mem_wr_dat
);
    import dmem_pkg::*;

    copy_state_t       state_q, state_d;
    logic [ADDR_W-1:0] rd_adr_q, rd_adr_d;
    logic [ADDR_W-1:0] wr_adr_q, wr_adr_d;
    logic [ADDR_W:0]   rd_cnt_q, rd_cnt_d;
    logic              rd_vld_q, rd_vld_d;
    logic              wr_en_q, wr_en_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [DATA_W-1:0] sum_q, sum_d;

    always_comb begin
        state_d  = state_q;
        rd_adr_d = rd_adr_q;
        wr_adr_d = wr_adr_q;
        rd_cnt_d = rd_cnt_q;
        rd_vld_d = rd_vld_q;
        wr_en_d  = wr_en_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        sum_d    = sum_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    sum_d    = '0;
                    wr_adr_d = dst_adr;
                    if (len != '0) begin
                        state_d  = RUN;
                        busy_d   = 1'b1;
                        rd_adr_d = src_adr;
                        rd_cnt_d = len - 1'b1;
                        rd_vld_d = 1'b1;
                    end else begin
                        state_d = FIN;
                        done_d  = 1'b1;
                    end
                end
            end
            RUN: begin
                // rd_vld_q marks an address the memory samples this edge; its data is written one edge later
                wr_en_d = rd_vld_q;
                if (rd_vld_q) begin
                    if (rd_cnt_q != '0) begin
                        rd_adr_d = rd_adr_q + 1'b1;
                        rd_cnt_d = rd_cnt_q - 1'b1;
                    end else begin
                        rd_vld_d = 1'b0;
                    end
                end
                if (wr_en_q) begin
                    sum_d    = sum_q + mem_rd_dat;
                    wr_adr_d = wr_adr_q + 1'b1;
                    if (!rd_vld_q) begin
                        state_d = FIN;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            rd_adr_q <= '0;
            wr_adr_q <= '0;
            rd_cnt_q <= '0;
            rd_vld_q <= 1'b0;
            wr_en_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            sum_q    <= '0;
        end else begin
            state_q  <= state_d;
            rd_adr_q <= rd_adr_d;
            wr_adr_q <= wr_adr_d;
            rd_cnt_q <= rd_cnt_d;
            rd_vld_q <= rd_vld_d;
            wr_en_q  <= wr_en_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            sum_q    <= sum_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign checksum   = sum_q;
    assign mem_rd_adr = rd_adr_q;
    assign mem_wr_en  = wr_en_q;
    assign mem_wr_adr = wr_adr_q;
    assign mem_wr_dat = mem_rd_dat;

endmodule

// File: tb/tb_dmem_copy_engine.sv
// Bench for dmem_copy_engine: directed table, multi-cycle corner sequences, randomized copies vs a memmove model.
module tb_dmem_copy_engine;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [9:0]  src_adr, dst_adr;
    logic [10:0] len;
    logic        busy, done;
    logic [15:0] checksum;
    logic [9:0]  mem_rd_adr, mem_wr_adr;
    logic [15:0] mem_rd_dat, mem_wr_dat;
    logic        mem_wr_en;

    always #5 clk = ~clk;

    dmem_copy_engine #(.ADDR_W(10), .DATA_W(16)) dut (
        .clk(clk), .reset(reset), .start(start),
        .src_adr(src_adr), .dst_adr(dst_adr), .len(len),
        .busy(busy), .done(done), .checksum(checksum),
        .mem_rd_adr(mem_rd_adr), .mem_rd_dat(mem_rd_dat),
        .mem_wr_en(mem_wr_en), .mem_wr_adr(mem_wr_adr), .mem_wr_dat(mem_wr_dat)
    );

    // 1-cycle-latency RAM, read-before-write on collision; pl_* is the bench's own preload port
    logic [15:0] mem [0:1023];
    logic        pl_we;
    logic [9:0]  pl_adr;
    logic [15:0] pl_dat;
    int          wr_cnt = 0;

    always @(posedge clk) begin
        mem_rd_dat <= mem[mem_rd_adr];
        if (pl_we) mem[pl_adr] <= pl_dat;
        else if (mem_wr_en) mem[mem_wr_adr] <= mem_wr_dat;
        if (mem_wr_en) wr_cnt <= wr_cnt + 1;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic load(input logic [9:0] a, input logic [15:0] d);
        pl_we = 1'b1; pl_adr = a; pl_dat = d;
        @(negedge clk);
        pl_we = 1'b0;
    endtask

    // Reference: memmove on a snapshot of memory, checksum = plain sum mod 2**16
    logic [15:0] expm [0:1023];
    logic [15:0] exp_sum;

    task automatic model_copy(input logic [9:0] s, input logic [9:0] d, input int l);
        logic [15:0] snap [0:1023];
        for (int i = 0; i < 1024; i++) begin snap[i] = mem[i]; expm[i] = mem[i]; end
        exp_sum = 16'h0;
        for (int k = 0; k < l; k++) begin
            expm[(int'(d) + k) % 1024] = snap[(int'(s) + k) % 1024];
            exp_sum = exp_sum + snap[(int'(s) + k) % 1024];
        end
    endtask

    function automatic int img_diff();
        int n = 0;
        for (int i = 0; i < 1024; i++) if (mem[i] !== expm[i]) n++;
        return n;
    endfunction

    int busy_n, done_at, done_n, writes;
    logic post_busy, post_wren;

    // Cycle c counts negedges after the start edge E0; inputs change right after sampling
    task automatic run_copy(input logic [9:0] s, input logic [9:0] d, input logic [10:0] l,
                            input int poke_at, input int rst_at);
        int w0;
        w0 = wr_cnt;
        busy_n = 0; done_at = 0; done_n = 0; post_busy = 1'b0; post_wren = 1'b0;
        src_adr = s; dst_adr = d; len = l; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c <= int'(l) + 30; c++) begin
            if (busy) busy_n++;
            if (done) begin done_n++; if (done_at == 0) done_at = c; end
            if (c == rst_at + 1) begin post_busy = busy; post_wren = mem_wr_en; end
            start = (c == poke_at);
            if (c == poke_at) begin src_adr = s ^ 10'h040; dst_adr = d + 10'h040; len = 11'd3; end
            reset = !(c == rst_at);
            @(negedge clk);
        end
        writes = wr_cnt - w0;
    endtask

    typedef struct {
        logic [9:0]       src, dst;
        logic [10:0]      len;
        logic [3:0][15:0] pre;
        logic [3:0][15:0] exp_w;
        logic [15:0]      exp_sum;
        int               exp_busy;
        int               exp_wr;
        logic [9:0]       chk_adr;
        logic [15:0]      chk_val;
    } vec_t;

    vec_t vecs [5];

    task automatic set_vec(input int i, input logic [9:0] s, input logic [9:0] d, input logic [10:0] l,
                           input logic [15:0] p0, p1, p2, p3, e0, e1, e2, e3, sm,
                           input int bz, input int wr, input logic [9:0] ca, input logic [15:0] cv);
        vecs[i].src = s; vecs[i].dst = d; vecs[i].len = l;
        vecs[i].pre[0] = p0; vecs[i].pre[1] = p1; vecs[i].pre[2] = p2; vecs[i].pre[3] = p3;
        vecs[i].exp_w[0] = e0; vecs[i].exp_w[1] = e1; vecs[i].exp_w[2] = e2; vecs[i].exp_w[3] = e3;
        vecs[i].exp_sum = sm; vecs[i].exp_busy = bz; vecs[i].exp_wr = wr;
        vecs[i].chk_adr = ca; vecs[i].chk_val = cv;
    endtask

    initial begin
        logic [9:0]  s, d, diff;
        logic [10:0] l;
        int          exp_done;

        reset = 1'b0; start = 1'b0; pl_we = 1'b0; pl_adr = '0; pl_dat = '0;
        src_adr = '0; dst_adr = '0; len = '0;

        set_vec(0, 10'h010, 10'h100, 11'd4, 16'h0001, 16'h0002, 16'h0003, 16'h0004,
                16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h000A, 5, 4, 10'h010, 16'h0001);
        set_vec(1, 10'h020, 10'h030, 11'd0, 16'h5555, 16'h6666, 16'h7777, 16'h8888,
                16'hDEAD, 16'hDEAD, 16'hDEAD, 16'hDEAD, 16'h0000, 0, 0, 10'h020, 16'h5555);
        // dst-src = 3 < len: word 3 reads 0x001 two edges after word 0 landed there
        set_vec(2, 10'h3FE, 10'h001, 11'd4, 16'h1111, 16'h2222, 16'h3333, 16'h4444,
                16'h1111, 16'h2222, 16'h3333, 16'h1111, 16'h7777, 5, 4, 10'h000, 16'h3333);
        set_vec(3, 10'h040, 10'h041, 11'd3, 16'hA000, 16'hB000, 16'hC000, 16'hD000,
                16'hA000, 16'hB000, 16'hC000, 16'hDEAD, 16'h1000, 4, 3, 10'h040, 16'hA000);
        set_vec(4, 10'h3FE, 10'h3FF, 11'd4, 16'h0101, 16'h0202, 16'h0303, 16'h0404,
                16'h0101, 16'h0202, 16'h0303, 16'h0404, 16'h0A0A, 5, 4, 10'h3FE, 16'h0101);

        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_checksum", checksum, 16'h0);
        chk("rst_rd_adr", mem_rd_adr, 10'h0);
        chk("rst_wr_en", mem_wr_en, 1'b0);
        chk("rst_wr_adr", mem_wr_adr, 10'h0);
        reset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            for (int k = 0; k < 4; k++) load(vecs[i].dst + 10'(k), 16'hDEAD);
            for (int k = 0; k < 4; k++) load(vecs[i].src + 10'(k), vecs[i].pre[k]);
            run_copy(vecs[i].src, vecs[i].dst, vecs[i].len, -1, -1);
            chk($sformatf("v%0d_busy_cycles", i), busy_n, vecs[i].exp_busy);
            chk($sformatf("v%0d_done_at", i), done_at, vecs[i].exp_busy + 1);
            chk($sformatf("v%0d_done_pulses", i), done_n, 1);
            chk($sformatf("v%0d_writes", i), writes, vecs[i].exp_wr);
            chk($sformatf("v%0d_checksum", i), checksum, vecs[i].exp_sum);
            for (int k = 0; k < 4; k++)
                chk($sformatf("v%0d_dst%0d", i, k), mem[vecs[i].dst + 10'(k)], vecs[i].exp_w[k]);
            chk($sformatf("v%0d_untouched", i), mem[vecs[i].chk_adr], vecs[i].chk_val);
        end

        for (int i = 0; i < 1024; i++) load(10'(i), 16'($urandom));

        // start re-pulsed during a len=8 copy must be ignored
        model_copy(10'h080, 10'h180, 8);
        run_copy(10'h080, 10'h180, 11'd8, 2, -1);
        chk("restart_writes", writes, 8);
        chk("restart_done_pulses", done_n, 1);
        chk("restart_checksum", checksum, exp_sum);
        chk("restart_image", img_diff(), 0);

        // reset sampled on the edge of the 3rd write
        model_copy(10'h0A0, 10'h1A0, 3);
        run_copy(10'h0A0, 10'h1A0, 11'd8, -1, 4);
        chk("rstmid_writes", writes, 3);
        chk("rstmid_done_pulses", done_n, 0);
        chk("rstmid_busy", post_busy, 1'b0);
        chk("rstmid_wr_en", post_wren, 1'b0);
        chk("rstmid_checksum", checksum, 16'h0);
        chk("rstmid_image", img_diff(), 0);
        model_copy(10'h0A0, 10'h1A0, 8);
        run_copy(10'h0A0, 10'h1A0, 11'd8, -1, -1);
        chk("after_rst_done_pulses", done_n, 1);
        chk("after_rst_checksum", checksum, exp_sum);
        chk("after_rst_image", img_diff(), 0);

        for (int t = 0; t < 20; t++) begin
            s = 10'($urandom);
            l = 11'($urandom_range(0, 40));
            do begin
                d = 10'($urandom);
                diff = d - s;
            end while (diff >= 10'd2 && 11'(diff) < l);
            exp_done = (l == 0) ? 1 : int'(l) + 2;
            model_copy(s, d, int'(l));
            run_copy(s, d, l, -1, -1);
            chk($sformatf("rnd%0d_done_at", t), done_at, exp_done);
            chk($sformatf("rnd%0d_done_pulses", t), done_n, 1);
            chk($sformatf("rnd%0d_writes", t), writes, int'(l));
            chk($sformatf("rnd%0d_checksum", t), checksum, exp_sum);
            chk($sformatf("rnd%0d_image", t), img_diff(), 0);
        end

        // full-memory rotate by one word: every address read and written, checksum wraps
        s = 10'($urandom);
        model_copy(s, s + 10'd1, 1024);
        run_copy(s, s + 10'd1, 11'd1024, -1, -1);
        chk("sweep_done_at", done_at, 1026);
        chk("sweep_writes", writes, 1024);
        chk("sweep_checksum", checksum, exp_sum);
        chk("sweep_image", img_diff(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
